// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receive path.
//   - rx_state_t : receive FSM state encodings (3 bits)
//   - C_SAMPLE_* : 16x oversampling sample points within one bit
//   - C_BIT_END  : last oversampling tick of a bit (counter wraps after it)
//   - C_DATA_W   : data bits per frame
//   - maj3       : 2-of-3 majority vote
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PARI  = 3'd3,
        ST_STOP  = 3'd4,
        ST_STOP2 = 3'd5
    } rx_state_t;

    localparam logic [3:0] C_SAMPLE_A = 4'd6;
    localparam logic [3:0] C_SAMPLE_B = 4'd7;
    localparam logic [3:0] C_SAMPLE_C = 4'd8;
    localparam logic [3:0] C_BIT_END  = 4'd15;

    localparam int C_DATA_W = 8;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: metastability synchronizer and falling-edge detector for the
// asynchronous RX line.
//   FPGA_CLK   in   system clock
//   FPGA_RST   in   asynchronous active-high reset (flops preset to idle-high)
//   IRXD       in   raw RX line
//   rxd_s      out  synchronized RX value
//   start_edge out  high for one clock when rxd_s falls (1 -> 0)
// P_SYNC_STAGES must be at least 2.
module uart_rx_sync #(
    parameter int P_SYNC_STAGES = 2
) (
    input  logic FPGA_CLK,
    input  logic FPGA_RST,
    input  logic IRXD,
    output logic rxd_s,
    output logic start_edge
);

    logic [P_SYNC_STAGES-1:0] sync_q;
    logic                     rxd_d;

    always_ff @(posedge FPGA_CLK or posedge FPGA_RST) begin
        if (FPGA_RST) begin
            sync_q <= '1;
            rxd_d  <= 1'b1;
        end else begin
            sync_q <= {sync_q[P_SYNC_STAGES-2:0], IRXD};
            rxd_d  <= sync_q[P_SYNC_STAGES-1];
        end
    end

    assign rxd_s      = sync_q[P_SYNC_STAGES-1];
    assign start_edge = rxd_d & ~rxd_s;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver (1 start, 8 data LSB first,
// optional parity, 1 or 2 stop bits).
//   FPGA_CLK    in   system clock
//   FPGA_RST    in   asynchronous active-high reset
//   IRXD        in   RX line, asynchronous, idles high
//   IPARITY_EN  in   parity bit present (latched at start detect)
//   IODD_PARITY in   1 = odd, 0 = even parity (latched at start detect)
//   ISTOP2_EN   in   check two stop bits (latched at start detect)
//   IBAUD_RATE  in   one-clock tick at 16x bit rate
//   ORX_DVLD    out  one-clock pulse, data and flags valid
//   ORX_DT      out  received byte
//   OPARITY_ERR out  parity mismatch on last frame
//   OFRAME_ERR  out  stop bit sampled low on last frame
//   ORX_BUSY    out  FSM not idle
//
// state | meaning
// IDLE  | waiting for falling edge on synchronized line
// START | checking start bit, false start returns to IDLE
// DATA  | shifting in 8 data bits, LSB first
// PARI  | capturing parity bit
// STOP  | checking first stop bit (single stop exits at its mid-bit decision)
// STOP2 | checking second stop bit, exits at its mid-bit decision
module uart_rx
    import uart_pkg::*;
#(
    parameter int P_SYNC_STAGES = 2
) (
    input  logic       FPGA_CLK,
    input  logic       FPGA_RST,
    input  logic       IRXD,
    input  logic       IPARITY_EN,
    input  logic       IODD_PARITY,
    input  logic       ISTOP2_EN,
    input  logic       IBAUD_RATE,
    output logic       ORX_DVLD,
    output logic [7:0] ORX_DT,
    output logic       OPARITY_ERR,
    output logic       OFRAME_ERR,
    output logic       ORX_BUSY
);

    rx_state_t             state_q;
    rx_state_t             state_d;

    logic                  rxd_s;
    logic                  start_edge;
    logic                  start_det;
    logic                  tick_act;
    logic                  bit_dec;
    logic                  bit_end;
    logic                  maj;
    logic                  frame_done;
    logic                  parity_exp;

    logic [3:0]            cnt16_q;
    logic [2:0]            cnt8_q;
    logic [C_DATA_W-1:0]   data_q;
    logic                  samp_a_q;
    logic                  samp_b_q;
    logic                  par_en_q;
    logic                  odd_q;
    logic                  stop2_q;
    logic                  par_bit_q;
    logic                  frame_q;
    logic                  dvld_pend_q;

    uart_rx_sync #(
        .P_SYNC_STAGES (P_SYNC_STAGES)
    ) u_sync (
        .FPGA_CLK   (FPGA_CLK),
        .FPGA_RST   (FPGA_RST),
        .IRXD       (IRXD),
        .rxd_s      (rxd_s),
        .start_edge (start_edge)
    );

    assign start_det = (state_q == ST_IDLE) && start_edge;
    assign tick_act  = IBAUD_RATE && (state_q != ST_IDLE);
    assign bit_dec   = tick_act && (cnt16_q == C_SAMPLE_C);
    assign bit_end   = tick_act && (cnt16_q == C_BIT_END);
    // Third vote is the live line value on the decision tick itself.
    assign maj       = maj3(samp_a_q, samp_b_q, rxd_s);
    assign parity_exp = (^data_q) ^ odd_q;
    assign ORX_BUSY  = (state_q != ST_IDLE);

    always_ff @(posedge FPGA_CLK or posedge FPGA_RST) begin
        if (FPGA_RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        frame_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_det) state_d = ST_START;
            end
            ST_START: begin
                if (bit_dec && maj) state_d = ST_IDLE;
                else if (bit_end)   state_d = ST_DATA;
            end
            ST_DATA: begin
                if (bit_end && (cnt8_q == 3'd7))
                    state_d = par_en_q ? ST_PARI : ST_STOP;
            end
            ST_PARI: begin
                if (bit_end) state_d = ST_STOP;
            end
            ST_STOP: begin
                // Single stop leaves at mid-bit so the next start edge is
                // caught even with zero idle between frames.
                if (bit_dec && !stop2_q) begin
                    state_d    = ST_IDLE;
                    frame_done = 1'b1;
                end else if (bit_end) begin
                    state_d = ST_STOP2;
                end
            end
            ST_STOP2: begin
                if (bit_dec) begin
                    state_d    = ST_IDLE;
                    frame_done = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge FPGA_CLK or posedge FPGA_RST) begin
        if (FPGA_RST) begin
            cnt16_q     <= 4'd0;
            cnt8_q      <= 3'd0;
            data_q      <= '0;
            samp_a_q    <= 1'b1;
            samp_b_q    <= 1'b1;
            par_en_q    <= 1'b0;
            odd_q       <= 1'b0;
            stop2_q     <= 1'b0;
            par_bit_q   <= 1'b0;
            frame_q     <= 1'b0;
            dvld_pend_q <= 1'b0;
        end else begin
            dvld_pend_q <= frame_done;

            if (state_q == ST_IDLE) begin
                cnt16_q <= 4'd0;
                cnt8_q  <= 3'd0;
            end else if (IBAUD_RATE) begin
                cnt16_q <= cnt16_q + 4'd1;
            end

            if (start_det) begin
                par_en_q <= IPARITY_EN;
                odd_q    <= IODD_PARITY;
                stop2_q  <= ISTOP2_EN;
                frame_q  <= 1'b0;
            end

            if (tick_act && (cnt16_q == C_SAMPLE_A)) samp_a_q <= rxd_s;
            if (tick_act && (cnt16_q == C_SAMPLE_B)) samp_b_q <= rxd_s;

            if (state_q == ST_DATA) begin
                if (bit_dec) data_q[cnt8_q] <= maj;
                if (bit_end) cnt8_q <= cnt8_q + 3'd1;
            end

            if ((state_q == ST_PARI) && bit_dec) par_bit_q <= maj;
            if ((state_q == ST_STOP) && bit_dec) frame_q <= ~maj;
            if ((state_q == ST_STOP2) && bit_dec) frame_q <= frame_q | ~maj;
        end
    end

    // Output register loads one clock after the final stop decision, when
    // frame_q has already absorbed that decision.
    always_ff @(posedge FPGA_CLK or posedge FPGA_RST) begin
        if (FPGA_RST) begin
            ORX_DVLD    <= 1'b0;
            ORX_DT      <= 8'h00;
            OPARITY_ERR <= 1'b0;
            OFRAME_ERR  <= 1'b0;
        end else begin
            ORX_DVLD <= dvld_pend_q;
            if (dvld_pend_q) begin
                ORX_DT      <= data_q;
                OPARITY_ERR <= par_en_q & (par_bit_q ^ parity_exp);
                OFRAME_ERR  <= frame_q;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    localparam int BIT_CLKS = 64;

    logic       FPGA_CLK = 1'b0;
    logic       FPGA_RST = 1'b1;
    logic       IRXD = 1'b1;
    logic       IPARITY_EN = 1'b0;
    logic       IODD_PARITY = 1'b0;
    logic       ISTOP2_EN = 1'b0;
    logic       IBAUD_RATE = 1'b0;
    logic       ORX_DVLD;
    logic [7:0] ORX_DT;
    logic       OPARITY_ERR;
    logic       OFRAME_ERR;
    logic       ORX_BUSY;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    exp_t exp_q[$];

    uart_rx #(.P_SYNC_STAGES(2)) dut (
        .FPGA_CLK    (FPGA_CLK),
        .FPGA_RST    (FPGA_RST),
        .IRXD        (IRXD),
        .IPARITY_EN  (IPARITY_EN),
        .IODD_PARITY (IODD_PARITY),
        .ISTOP2_EN   (ISTOP2_EN),
        .IBAUD_RATE  (IBAUD_RATE),
        .ORX_DVLD    (ORX_DVLD),
        .ORX_DT      (ORX_DT),
        .OPARITY_ERR (OPARITY_ERR),
        .OFRAME_ERR  (OFRAME_ERR),
        .ORX_BUSY    (ORX_BUSY)
    );

    // Tick updated just before the falling edge so negedge processes see a
    // consistent phase counter.
    initial begin
        forever begin
            #5 FPGA_CLK = 1'b1;
            #5 cyc = cyc + 1;
            IBAUD_RATE = ((cyc % 4) == 0);
            FPGA_CLK = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge FPGA_CLK);
    endtask

    task automatic align();
        @(negedge FPGA_CLK);
        while ((cyc % 4) != 0) @(negedge FPGA_CLK);
    endtask

    task automatic send_bit(input logic v, input bit glitch);
        IRXD = v;
        if (glitch) begin
            hold(28);
            IRXD = ~v;
            hold(4);
            IRXD = v;
            hold(BIT_CLKS - 32);
        end else begin
            hold(BIT_CLKS);
        end
    endtask

    // glitch_idx: data bit index to glitch at its 7th sample, or -1.
    task automatic send_frame(input logic [7:0] d, input bit with_par, input logic pbit,
                              input logic s1, input int nstop, input logic s2,
                              input int glitch_idx);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i], (i == glitch_idx));
        if (with_par) send_bit(pbit, 1'b0);
        send_bit(s1, 1'b0);
        if (nstop == 2) send_bit(s2, 1'b0);
        IRXD = 1'b1;
    endtask

    task automatic push(input logic [7:0] d, input logic pe, input logic fe);
        exp_t e;
        e.d  = d;
        e.pe = pe;
        e.fe = fe;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge FPGA_CLK);
            n++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    task automatic chk_outs_zero(input string tag);
        chk({tag, "_dt"}, ORX_DT, 8'h00);
        chk({tag, "_dvld"}, ORX_DVLD, 0);
        chk({tag, "_perr"}, OPARITY_ERR, 0);
        chk({tag, "_ferr"}, OFRAME_ERR, 0);
        chk({tag, "_busy"}, ORX_BUSY, 0);
    endtask

    // Monitor / scoreboard
    initial begin
        exp_t e;
        logic prev_dvld;
        prev_dvld = 1'b0;
        forever begin
            @(negedge FPGA_CLK);
            if (ORX_DVLD === 1'b1) begin
                chk("dvld_one_cycle", prev_dvld, 0);
                chk("busy_low_at_dvld", ORX_BUSY, 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_dvld actual_dt=%0h perr=%0b ferr=%0b required=no pulse t=%0t",
                             ORX_DT, OPARITY_ERR, OFRAME_ERR, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("rx_data", ORX_DT, e.d);
                    chk("parity_err", OPARITY_ERR, e.pe);
                    chk("frame_err", OFRAME_ERR, e.fe);
                end
            end
            prev_dvld = ORX_DVLD;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        hold(5);
        chk_outs_zero("reset");
        FPGA_RST = 1'b0;
        hold(20);

        // 8N1 0xA5
        align();
        push(8'hA5, 0, 0);
        send_bit(1'b0, 1'b0);
        chk("busy_mid_frame", ORX_BUSY, 1);
        for (int i = 0; i < 8; i++) send_bit(((8'hA5 >> i) & 8'h01) != 0, 1'b0);
        send_bit(1'b1, 1'b0);
        hold(2 * BIT_CLKS);
        wait_drain("drain_a5");

        // 0x3C even parity (bit 0), then odd parity with bit 0 -> error.
        // Odd config is flipped back mid-frame; the latched value must win.
        IPARITY_EN = 1'b1;
        IODD_PARITY = 1'b0;
        align();
        push(8'h3C, 0, 0);
        send_frame(8'h3C, 1, 1'b0, 1'b1, 1, 1'b1, -1);
        hold(2 * BIT_CLKS);
        IODD_PARITY = 1'b1;
        align();
        push(8'h3C, 1, 0);
        fork
            send_frame(8'h3C, 1, 1'b0, 1'b1, 1, 1'b1, -1);
            begin
                hold(300);
                IODD_PARITY = 1'b0;
            end
        join
        hold(2 * BIT_CLKS);
        wait_drain("drain_parity");
        IPARITY_EN = 1'b0;

        // 0x81 with two stop bits, second low -> frame error
        ISTOP2_EN = 1'b1;
        align();
        push(8'h81, 0, 1);
        send_frame(8'h81, 0, 1'b0, 1'b1, 2, 1'b0, -1);
        hold(2 * BIT_CLKS);
        wait_drain("drain_stop2");
        // Same waveform with one stop: clean 0x81, then the low bit is a
        // start bit followed by an all-high line -> 0xFF.
        ISTOP2_EN = 1'b0;
        align();
        push(8'h81, 0, 0);
        push(8'hFF, 0, 0);
        send_frame(8'h81, 0, 1'b0, 1'b1, 2, 1'b0, -1);
        hold(10 * BIT_CLKS);
        wait_drain("drain_stop1");

        // 5-tick low pulse (false start), then 0x55
        align();
        IRXD = 1'b0;
        hold(20);
        IRXD = 1'b1;
        hold(2 * BIT_CLKS);
        align();
        push(8'h55, 0, 0);
        send_frame(8'h55, 0, 1'b0, 1'b1, 1, 1'b1, -1);
        hold(2 * BIT_CLKS);
        wait_drain("drain_55");

        // Back-to-back 0x01, 0xFE, glitch at 7th sample of data bit 3
        align();
        push(8'h01, 0, 0);
        push(8'hFE, 0, 0);
        send_frame(8'h01, 0, 1'b0, 1'b1, 1, 1'b1, 3);
        send_frame(8'hFE, 0, 1'b0, 1'b1, 1, 1'b1, -1);
        hold(2 * BIT_CLKS);
        wait_drain("drain_b2b");

        // Reset during data bit 4 of 0x5A: frame discarded
        align();
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(((8'h5A >> i) & 8'h01) != 0, 1'b0);
        IRXD = 1'b1;
        hold(32);
        FPGA_RST = 1'b1;
        hold(4);
        chk_outs_zero("in_reset");
        FPGA_RST = 1'b0;
        hold(10 * BIT_CLKS);
        chk_outs_zero("after_reset");

        align();
        push(8'hC3, 0, 0);
        send_frame(8'hC3, 0, 1'b0, 1'b1, 1, 1'b1, -1);
        hold(2 * BIT_CLKS);
        wait_drain("drain_c3");

        // Break: 12 bit times low -> single 0x00 with frame error
        align();
        push(8'h00, 0, 1);
        IRXD = 1'b0;
        hold(12 * BIT_CLKS);
        chk("busy_idle_in_break", ORX_BUSY, 0);
        IRXD = 1'b1;
        hold(4 * BIT_CLKS);
        wait_drain("drain_break");
        chk("break_ferr_held", OFRAME_ERR, 1);
        chk("break_dt_held", ORX_DT, 8'h00);

        hold(200);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
